imm_fetch_sequencer: RTL and testbench
======================================

Name: imm_fetch_sequencer

Overview:
- Sits between instruction fetch and decode.
- Recognises two-word LDM instructions, whose 16-bit immediate occupies the following fetched word.
- Joins the opcode word and the immediate word into one decode-stage bundle and drives the LDM select that steers the immediate mux in decode.
- Passes single-word instructions through with one cycle of latency, and handles stall and flush.

Parameters:
- LDM_OPCODE, 5'b11001, value of instr[15:11] that marks a two-word LDM
- TIMEOUT_CYCLES, 8, wait limit for the immediate word; used only with IMM_TIMEOUT_EN
- CNT_W, 4, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr_in  in  16  word from fetch
- instr_valid  in  1  instr_in is valid this cycle
- in_ready  out  1  sequencer accepts instr_in this cycle
- stall_in  in  1  decode cannot take a new bundle; hold outputs
- flush  in  1  branch or interrupt flush; discard everything in flight
- instr_out  out  16  instruction word to decode
- imm_out  out  16  immediate word to decode; 0 for single-word instructions
- ldm_sel  out  1  bundle carries an LDM immediate
- out_valid  out  1  bundle valid
- imm_err  out  1  one-cycle pulse when an immediate is abandoned (timeout)

Behaviour:
- One clock. Reset is asynchronous, active-low on rst_n.
- While rst_n=0:
  - state=S_PASS
  - instr_out, imm_out, held word = 16'h0000
  - ldm_sel=0, out_valid=0, imm_err=0, counter=0
- in_ready = ~stall_in (combinational).
- accept = instr_valid & in_ready.
- All outputs are registered.
- Priority each cycle: flush > stall_in > accept.
- flush=1:
  - next state S_PASS; out_valid=0, ldm_sel=0; held word discarded; counter=0.
  - Applies even when stall_in=1.
  - A word presented in the same cycle is dropped.
- stall_in=1 (no flush): every register holds, state included.
- S_PASS:
  - accept with instr_in[15:11]!=LDM_OPCODE: next cycle instr_out=instr_in, imm_out=0, ldm_sel=0, out_valid=1. Latency 1.
  - accept with instr_in[15:11]==LDM_OPCODE: capture the word into the held register, out_valid=0 next cycle (bubble), go to S_WAIT_IMM.
  - No accept: out_valid=0.
- S_WAIT_IMM:
  - accept: next cycle instr_out=held word, imm_out=instr_in, ldm_sel=1, out_valid=1, go to S_PASS.
  - The immediate word is never decoded, even if its bits [15:11] match LDM_OPCODE.
  - No accept: out_valid=0, stay in S_WAIT_IMM.
- LDM latency: bundle valid one cycle after the immediate is accepted, so two cycles minimum after the opcode word.
- Back-to-back traffic:
  - An LDM opcode arriving in S_PASS directly after an LDM bundle starts a new sequence normally.
  - Single-word throughput is 1 per cycle.
- Reset asserted mid-sequence discards the held word; no bundle is emitted.

Optional Feature:
- Macro: IMM_TIMEOUT_EN
- Defined:
  - The counter clears on entry to S_WAIT_IMM and increments on every S_WAIT_IMM cycle with no accept and no stall.
  - When it reaches TIMEOUT_CYCLES: imm_err=1 for one cycle, held word dropped, state returns to S_PASS, out_valid=0.
  - flush clears the counter.
- Not defined: no counter is built, imm_err is tied to 0, and S_WAIT_IMM waits indefinitely.

Decomposition:
- Shared package isa_pkg:
  - opcode constants, including LDM_OPCODE default
  - state enum {S_PASS, S_WAIT_IMM}
  - INSTR_W=16
- No sub-module. The FSM, output register and optional counter live in one module.

Test Plan:
- Single-word stream: 16'h1234 then 16'h2001, each with instr_valid=1.
  - Expect out_valid=1 on cycles +1 and +2, instr_out=16'h1234 then 16'h2001, imm_out=0, ldm_sel=0.
- LDM pair: 16'hC800 then 16'hBEEF.
  - Expect a bubble on cycle +1.
  - Cycle +2: instr_out=16'hC800, imm_out=16'hBEEF, ldm_sel=1.
- Immediate that looks like LDM: 16'hC800 then 16'hC8FF.
  - Expect one bundle with imm_out=16'hC8FF, then the FSM in S_PASS.
- Stall: stall_in=1 for 3 cycles during S_WAIT_IMM, with valid words offered.
  - Expect in_ready=0, outputs held, state held.
  - After release, the immediate is consumed correctly.
- Flush: flush=1 in S_WAIT_IMM with stall_in=1.
  - Expect out_valid=0, state S_PASS.
  - The next word 16'h1234 passes as single-word.
- Timeout (IMM_TIMEOUT_EN, TIMEOUT_CYCLES=8): 16'hC800 followed by 8 idle cycles.
  - Expect a single imm_err pulse and state S_PASS.
  - The next 16'hBEEF is treated as a single-word instruction.
  - With the macro not defined, imm_err stays 0 throughout.

Source files
------------

// File: rtl/isa_pkg.sv
// ---------------------------------------------------------------------------
// isa_pkg
//
// Shared ISA definitions for the fetch/decode boundary.
//   - INSTR_W        : instruction word width
//   - opcode constants (instr[15:11]), including the two-word LDM opcode
//   - seq_state_e    : state encoding for imm_fetch_sequencer
//   - isOpcode()     : helper that tests the opcode field of a word
//
// Optional build macro used by consumers of this package: IMM_TIMEOUT_EN
// ---------------------------------------------------------------------------
package isa_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_W   = 5;

  // Opcode field values (instr[15:11]).
  localparam logic [OPC_W-1:0] OPC_NOP        = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_ALU        = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_BRANCH     = 5'b10111;
  localparam logic [OPC_W-1:0] LDM_OPCODE_DEF = 5'b11001;

  // S_PASS     : words flow straight through with one cycle of latency
  // S_WAIT_IMM : an LDM opcode word is held, waiting for its immediate
  typedef enum logic {
    S_PASS     = 1'b0,
    S_WAIT_IMM = 1'b1
  } seq_state_e;

  function automatic logic isOpcode(input logic [INSTR_W-1:0] word,
                                    input logic [OPC_W-1:0]   opc);
    return word[INSTR_W-1 -: OPC_W] == opc;
  endfunction

endpackage

// File: rtl/imm_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// imm_fetch_sequencer
//
// Sits between instruction fetch and decode. Two-word LDM instructions carry
// a 16-bit immediate in the following fetched word; this block joins the
// opcode word and the immediate word into one decode bundle and raises
// ldm_sel so decode steers its immediate mux. Single-word instructions pass
// through with one cycle of latency. All outputs are registered.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   instr_in     in   [15:0] word from fetch
//   instr_valid  in   instr_in is valid this cycle
//   in_ready     out  word accepted this cycle (= ~stall_in)
//   stall_in     in   decode cannot take a new bundle; everything holds
//   flush        in   discard everything in flight (beats stall)
//   instr_out    out  [15:0] instruction word to decode
//   imm_out      out  [15:0] immediate to decode (0 for single-word)
//   ldm_sel      out  bundle carries an LDM immediate
//   out_valid    out  bundle valid
//   imm_err      out  one-cycle pulse when a pending immediate times out
//
// Build macro:
//   IMM_TIMEOUT_EN  defined   : S_WAIT_IMM gives up after TIMEOUT_CYCLES idle
//                               (non-stalled) cycles and pulses imm_err
//                   undefined : no counter, imm_err tied low, waits forever
// ---------------------------------------------------------------------------
module imm_fetch_sequencer
  import isa_pkg::*;
#(
  parameter logic [OPC_W-1:0] LDM_OPCODE     = LDM_OPCODE_DEF,
  parameter int               TIMEOUT_CYCLES = 8,
  parameter int               CNT_W          = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               instr_valid,
  output logic               in_ready,
  input  logic               stall_in,
  input  logic               flush,
  output logic [INSTR_W-1:0] instr_out,
  output logic [INSTR_W-1:0] imm_out,
  output logic               ldm_sel,
  output logic               out_valid,
  output logic               imm_err
);

  // The timeout counter must be able to hold TIMEOUT_CYCLES-1 without wrap.
  if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : gCntWidthCheck
    $error("imm_fetch_sequencer: CNT_W too small for TIMEOUT_CYCLES");
  end

  seq_state_e         state_q, state_d;
  logic [INSTR_W-1:0] heldWord_q, heldWord_d;
  logic [INSTR_W-1:0] instrOut_q, instrOut_d;
  logic [INSTR_W-1:0] immOut_q, immOut_d;
  logic               ldmSel_q, ldmSel_d;
  logic               outValid_q, outValid_d;
  logic               accept;

`ifdef IMM_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               immErr_q, immErr_d;
`endif

  assign in_ready = ~stall_in;
  assign accept   = instr_valid & in_ready;

  // Next-state logic. Priority is flush, then stall, then accept. A stall
  // freezes every register except imm_err, which is a strict one-cycle pulse.
  always_comb begin
    state_d    = state_q;
    heldWord_d = heldWord_q;
    instrOut_d = instrOut_q;
    immOut_d   = immOut_q;
    ldmSel_d   = ldmSel_q;
    outValid_d = outValid_q;
`ifdef IMM_TIMEOUT_EN
    cnt_d      = cnt_q;
    immErr_d   = 1'b0;
`endif

    if (flush) begin
      state_d    = S_PASS;
      heldWord_d = '0;
      outValid_d = 1'b0;
      ldmSel_d   = 1'b0;
`ifdef IMM_TIMEOUT_EN
      cnt_d      = '0;
`endif
    end else if (!stall_in) begin
      outValid_d = 1'b0;
      ldmSel_d   = 1'b0;
      unique case (state_q)
        S_PASS: begin
          if (accept) begin
            if (isOpcode(instr_in, LDM_OPCODE)) begin
              // Opcode half of an LDM: park it and emit a bubble.
              heldWord_d = instr_in;
              state_d    = S_WAIT_IMM;
`ifdef IMM_TIMEOUT_EN
              cnt_d      = '0;
`endif
            end else begin
              instrOut_d = instr_in;
              immOut_d   = '0;
              outValid_d = 1'b1;
            end
          end
        end
        S_WAIT_IMM: begin
          if (accept) begin
            // The word here is data, never decoded, even if it looks like LDM.
            instrOut_d = heldWord_q;
            immOut_d   = instr_in;
            ldmSel_d   = 1'b1;
            outValid_d = 1'b1;
            heldWord_d = '0;
            state_d    = S_PASS;
          end else begin
`ifdef IMM_TIMEOUT_EN
            if (cnt_q == TimeoutLast) begin
              immErr_d   = 1'b1;
              heldWord_d = '0;
              cnt_d      = '0;
              state_d    = S_PASS;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
`endif
          end
        end
        default: state_d = S_PASS;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_PASS;
      heldWord_q <= '0;
      instrOut_q <= '0;
      immOut_q   <= '0;
      ldmSel_q   <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      heldWord_q <= heldWord_d;
      instrOut_q <= instrOut_d;
      immOut_q   <= immOut_d;
      ldmSel_q   <= ldmSel_d;
      outValid_q <= outValid_d;
    end
  end

`ifdef IMM_TIMEOUT_EN
  // Immediate-wait timeout counter and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      immErr_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      immErr_q <= immErr_d;
    end
  end

  assign imm_err = immErr_q;
`else
  assign imm_err = 1'b0;
`endif

  assign instr_out = instrOut_q;
  assign imm_out   = immOut_q;
  assign ldm_sel   = ldmSel_q;
  assign out_valid = outValid_q;

endmodule

// File: tb/tb_imm_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_imm_fetch_sequencer
//
// Self-checking bench for imm_fetch_sequencer. Each driven cycle runs the
// stimulus through a small reference model that pushes the expected output
// for the following clock edge onto a queue; after the edge the entry is
// popped and compared against the DUT. Honours IMM_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_imm_fetch_sequencer;

  localparam logic [4:0] LdmOpc     = 5'b11001;
  localparam int         TimeoutCyc = 8;

  typedef struct {
    logic        valid;
    logic [15:0] instr;
    logic [15:0] imm;
    logic        ldm;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] instr_in;
  logic        instr_valid;
  logic        in_ready;
  logic        stall_in;
  logic        flush;
  logic [15:0] instr_out;
  logic [15:0] imm_out;
  logic        ldm_sel;
  logic        out_valid;
  logic        imm_err;

  int   errorCount = 0;
  int   checkCount = 0;
  exp_t expQ[$];

  // Reference model state.
  logic        mWait;
  logic [15:0] mHeld;
  int          mCnt;
  exp_t        mLast;

  imm_fetch_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_in   (instr_in),
    .instr_valid(instr_valid),
    .in_ready   (in_ready),
    .stall_in   (stall_in),
    .flush      (flush),
    .instr_out  (instr_out),
    .imm_out    (imm_out),
    .ldm_sel    (ldm_sel),
    .out_valid  (out_valid),
    .imm_err    (imm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mWait       = 1'b0;
    mHeld       = '0;
    mCnt        = 0;
    mLast.valid = 1'b0;
    mLast.instr = '0;
    mLast.imm   = '0;
    mLast.ldm   = 1'b0;
    mLast.err   = 1'b0;
  endtask

  // Reference model: compute what the DUT should show after the next edge.
  task automatic modelStep(input logic [15:0] word, input logic valid,
                           input logic stall, input logic fl);
    exp_t e;
    e     = mLast;
    e.err = 1'b0;
    if (fl) begin
      e.valid = 1'b0;
      e.ldm   = 1'b0;
      mWait   = 1'b0;
      mHeld   = '0;
      mCnt    = 0;
    end else if (!stall) begin
      e.valid = 1'b0;
      e.ldm   = 1'b0;
      if (valid) begin
        if (!mWait) begin
          if (word[15:11] == LdmOpc) begin
            mHeld = word;
            mWait = 1'b1;
            mCnt  = 0;
          end else begin
            e.valid = 1'b1;
            e.instr = word;
            e.imm   = '0;
          end
        end else begin
          e.valid = 1'b1;
          e.instr = mHeld;
          e.imm   = word;
          e.ldm   = 1'b1;
          mWait   = 1'b0;
        end
      end else if (mWait) begin
`ifdef IMM_TIMEOUT_EN
        mCnt++;
        if (mCnt == TimeoutCyc) begin
          e.err = 1'b1;
          mWait = 1'b0;
          mHeld = '0;
          mCnt  = 0;
        end
`endif
      end
    end
    mLast = e;
    expQ.push_back(e);
  endtask

  // Drive one cycle of stimulus, then compare the DUT after the edge.
  task automatic applyStimulus(input string tag, input logic [15:0] word,
                               input logic valid, input logic stall,
                               input logic fl);
    exp_t e;
    @(negedge clk);
    instr_in    = word;
    instr_valid = valid;
    stall_in    = stall;
    flush       = fl;
    #1;
    checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'(!stall));
    modelStep(word, valid, stall, fl);
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      checkOutput({tag, ".queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = expQ.pop_front();
      checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(e.valid));
      checkOutput({tag, ".imm_err"}, 32'(imm_err), 32'(e.err));
      if (e.valid) begin
        checkOutput({tag, ".instr_out"}, 32'(instr_out), 32'(e.instr));
        checkOutput({tag, ".imm_out"}, 32'(imm_out), 32'(e.imm));
        checkOutput({tag, ".ldm_sel"}, 32'(ldm_sel), 32'(e.ldm));
      end
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".instr_out"}, 32'(instr_out), 32'h0);
    checkOutput({tag, ".imm_out"}, 32'(imm_out), 32'h0);
    checkOutput({tag, ".ldm_sel"}, 32'(ldm_sel), 32'h0);
    checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'h0);
    checkOutput({tag, ".imm_err"}, 32'(imm_err), 32'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    instr_in    = '0;
    instr_valid = 1'b0;
    stall_in    = 1'b0;
    flush       = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single-word stream.
    applyStimulus("single0", 16'h1234, 1'b1, 1'b0, 1'b0);
    applyStimulus("single1", 16'h2001, 1'b1, 1'b0, 1'b0);
    applyStimulus("idle0",   16'h5555, 1'b0, 1'b0, 1'b0);

    // LDM pair, followed immediately by a second LDM sequence whose
    // immediate looks like an LDM opcode.
    applyStimulus("ldmOp",   16'hC800, 1'b1, 1'b0, 1'b0);
    applyStimulus("ldmImm",  16'hBEEF, 1'b1, 1'b0, 1'b0);
    applyStimulus("ldm2Op",  16'hC800, 1'b1, 1'b0, 1'b0);
    applyStimulus("ldm2Imm", 16'hC8FF, 1'b1, 1'b0, 1'b0);
    applyStimulus("afterLd", 16'h1234, 1'b1, 1'b0, 1'b0);

    // Stall with a valid bundle on the outputs: bundle must hold.
    applyStimulus("holdSrc", 16'h4321, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++)
      applyStimulus("holdStl", 16'h0F0F, 1'b1, 1'b1, 1'b0);

    // Stall in S_WAIT_IMM with words offered, then the immediate.
    applyStimulus("stlOp",   16'hC800, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus("stlWait", 16'hAAAA, 1'b1, 1'b1, 1'b0);
    applyStimulus("stlImm",  16'h5678, 1'b1, 1'b0, 1'b0);

    // Flush beats stall in S_WAIT_IMM; next word is single-word.
    applyStimulus("flOp",    16'hC800, 1'b1, 1'b0, 1'b0);
    applyStimulus("flush",   16'hAAAA, 1'b1, 1'b1, 1'b1);
    applyStimulus("flNext",  16'h1234, 1'b1, 1'b0, 1'b0);

    // Timeout: LDM opcode then idle; BEEF behaviour depends on the build.
    applyStimulus("toOp",    16'hC800, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < TimeoutCyc; i++)
      applyStimulus("toIdle", 16'h0000, 1'b0, 1'b0, 1'b0);
    applyStimulus("toNext",  16'hBEEF, 1'b1, 1'b0, 1'b0);
    applyStimulus("toIdleB", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Reset mid-sequence drops the held word.
    applyStimulus("rstOp",   16'hC800, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    instr_valid = 1'b0;
    rst_n       = 1'b0;
    #1;
    checkResetOutputs("midReset");
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("rstNext", 16'hBEEF, 1'b1, 1'b0, 1'b0);
    applyStimulus("rstIdle", 16'h0000, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
